// File: rtl/viterbi_pkg.sv
// viterbi_pkg: controller state encoding and symbol constants shared with the core and wrapper
package viterbi_pkg;
  typedef enum logic [2:0] {IDLE, INIT, DATA, FLUSH, DONE} ctrl_state_e;
  localparam logic [1:0] SYM_ZERO = 2'b00;
endpackage

// File: rtl/viterbi_bit_packer.sv
// viterbi_bit_packer: packs decoded bits LSB-first into bytes behind a one-entry holding register
module viterbi_bit_packer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       take,
  input  logic       bit_in,
  input  logic [2:0] pos,
  input  logic       final_bit,
  input  logic       force_out,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_byte,
  output logic       out_last,
  output logic       err_overrun
);
  logic [7:0] sr, nxt;
  logic last, complete;
  always_comb begin
    nxt = sr;
    if (take) nxt[pos] = bit_in;
  end
  assign last = force_out | (take & final_bit);
  assign complete = last | (take & (pos == 3'd7));
  // shift reg clears on every completion so a short final byte is zero-padded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr          <= '0;
      out_valid   <= 1'b0;
      out_byte    <= '0;
      out_last    <= 1'b0;
      err_overrun <= 1'b0;
    end else if (clear) begin
      sr          <= '0;
      err_overrun <= 1'b0;
    end else begin
      sr <= complete ? '0 : nxt;
      if (complete && out_valid && !out_ready) err_overrun <= 1'b1;
      else if (complete) begin
        out_valid <= 1'b1;
        out_byte  <= nxt;
        out_last  <= last;
      end else if (out_valid && out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: frame sequencer feeding the viterbi core, appending flush symbols
// until every decoded bit of the frame is collected and packed into bytes.
module viterbi_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter int K     = 3,
  parameter int D_TB  = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             host_sym_valid,
  input  logic [1:0]       host_sym,
  output logic             host_sym_ready,
  output logic             core_sym_valid,
  output logic [1:0]       core_sym,
  input  logic             core_sym_ready,
  output logic             core_force_s0,
  input  logic             core_dec_valid,
  input  logic             core_dec_bit,
  output logic             out_valid,
  output logic [7:0]       out_byte,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             err_overrun,
  output logic             err_flush
);
  localparam int FLUSH_MAX = D_TB + K + 2;
  localparam int FW = $clog2(FLUSH_MAX + 1);
  ctrl_state_e state, state_nx;
  logic [LEN_W-1:0] len_q, sym_cnt, bit_cnt;
  logic [FW-1:0] flush_cnt;
  logic start, take, core_hs, bits_done, flush_timeout;
  assign busy = (state != IDLE) | out_valid;
  assign start = frame_start & (frame_len != '0) & !busy;
  assign bits_done = bit_cnt == len_q;
  assign flush_timeout = (state == FLUSH) & !bits_done & (flush_cnt == FW'(FLUSH_MAX));
  assign take = core_dec_valid & (state inside {INIT, DATA, FLUSH}) & !bits_done;
  assign core_hs = core_sym_valid & core_sym_ready;
  always_comb begin
    state_nx       = state;
    core_force_s0  = 1'b0;
    core_sym_valid = 1'b0;
    core_sym       = SYM_ZERO;
    host_sym_ready = 1'b0;
    case (state)
      IDLE: state_nx = start ? INIT : IDLE;
      INIT: begin
        core_force_s0 = 1'b1;
        state_nx      = DATA;
      end
      DATA: begin
        core_sym_valid = host_sym_valid;
        core_sym       = host_sym;
        host_sym_ready = core_sym_ready;
        state_nx = (host_sym_valid && core_sym_ready && sym_cnt == len_q - 1'b1) ? FLUSH : DATA;
      end
      FLUSH: begin
        core_sym_valid = !(bits_done || flush_timeout);
        state_nx       = (bits_done || flush_timeout) ? DONE : FLUSH;
      end
      DONE: state_nx = out_valid ? DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      sym_cnt   <= '0;
      bit_cnt   <= '0;
      flush_cnt <= '0;
      err_flush <= 1'b0;
    end else begin
      state <= state_nx;
      if (start) begin
        len_q     <= frame_len;
        sym_cnt   <= '0;
        bit_cnt   <= '0;
        flush_cnt <= '0;
        err_flush <= 1'b0;
      end else begin
        if (state == DATA && core_hs) sym_cnt <= sym_cnt + 1'b1;
        if (state == FLUSH && core_hs) flush_cnt <= flush_cnt + 1'b1;
        if (take) bit_cnt <= bit_cnt + 1'b1;
        if (flush_timeout) err_flush <= 1'b1;
      end
    end
  end
  viterbi_bit_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start),
    .take       (take),
    .bit_in     (core_dec_bit),
    .pos        (bit_cnt[2:0]),
    .final_bit  (bit_cnt == len_q - 1'b1),
    .force_out  (flush_timeout),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_byte   (out_byte),
    .out_last   (out_last),
    .err_overrun(err_overrun)
  );
endmodule
